// File: rtl/router_pkg.sv
// Shared constants and types for the router's per-destination output buffers.
package router_pkg;

  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_ADDR_W = 4;
  localparam int unsigned BYTE_W      = 8;

  // Header byte layout: {payload length, destination address}
  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

  typedef struct packed {
    logic              hdr;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  // Bytes still to deliver once a header has been read: payload plus parity.
  function automatic logic [6:0] pkt_len(logic [BYTE_W-1:0] hdr_byte);
    return {1'b0, hdr_byte[LEN_MSB:LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Storage array: synchronous write, asynchronous read. The output register lives in the
// parent so the header flag of the entry at the read pointer can steer the packet counter.
module router_fifo_ram #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Tracks packet length from the header so
// data_out falls back to zero once the parity byte has been delivered.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned WIDTH  = BYTE_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             flush;
  logic             wr_fire, rd_fire;
  fifo_entry_t      wr_entry, rd_entry;

  assign flush = !resetn || soft_reset;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // Both flags come from the pre-edge pointers, so a read at full never frees a slot
  // for a write in the same cycle, and a write into empty is never read through.
  assign wr_fire = write_enb && !full && !flush;
  assign rd_fire = read_enb && !empty && !flush;

  assign wr_entry = '{hdr: lfd_state, data: data_in};

  router_fifo_ram #(
    .Width ($bits(fifo_entry_t)),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end

    if (rd_fire) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = rd_entry.data;
      if (rd_entry.hdr) begin
        pkt_cnt_d = pkt_len(rd_entry.data);
      end else if (pkt_cnt_q != 7'd0) begin
        pkt_cnt_d = pkt_cnt_q - 7'd1;
      end
    end else if (pkt_cnt_q == 7'd0) begin
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule
